// File: rtl/ctrl_payload_tx.sv
// ctrl_payload_tx: packetiser emitting a UDP header, a 6-byte app header and big-endian out-RAM words
//   start, exec_len/seq/err, dest_ip, src_port, dest_port: command, sampled on start while idle
//   ram_addr, ram_rd, ram_q: out-RAM read port with 1-cycle read latency
//   udp_hdr_*, udp_ip_dest_ip, udp_source_port, udp_dest_port, udp_length: UDP header handshake
//   udp_payload_axis_*: payload byte stream; busy, done: status
module ctrl_payload_tx #(
  parameter int ADDR_WIDTH    = 10,
  parameter int APP_HDR_BYTES = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   exec_len,
  input  logic [15:0]           exec_seq,
  input  logic                  exec_err,
  input  logic [31:0]           dest_ip,
  input  logic [15:0]           src_port,
  input  logic [15:0]           dest_port,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd,
  input  logic [15:0]           ram_q,
  output logic                  udp_hdr_valid,
  input  logic                  udp_hdr_ready,
  output logic [31:0]           udp_ip_dest_ip,
  output logic [15:0]           udp_source_port,
  output logic [15:0]           udp_dest_port,
  output logic [15:0]           udp_length,
  output logic [7:0]            udp_payload_axis_tdata,
  output logic                  udp_payload_axis_tvalid,
  input  logic                  udp_payload_axis_tready,
  output logic                  udp_payload_axis_tlast,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, UHDR, AHDR, DATA} state_t;
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [2:0] HB = 3'(APP_HDR_BYTES);
  localparam logic [2:0] HL = 3'(APP_HDR_BYTES - 1);
  state_t state;
  logic [15:0] seq, buf0, buf1, len16;
  logic err, lo, inflight, load, fire, push, pop, have_word, issue;
  logic [ADDR_WIDTH:0] len, len_in, rcnt, wcnt;
  logic [2:0] hcnt;
  logic [1:0] cnt, cnt_next;
  logic [7:0] hbyte;
  assign len_in = exec_len > MAX_LEN ? MAX_LEN : exec_len;
  assign len16 = 16'(len);
  assign load = !udp_payload_axis_tvalid || udp_payload_axis_tready;
  assign fire = udp_payload_axis_tvalid && udp_payload_axis_tready;
  // a read issued last cycle returns its word this cycle
  assign push = inflight;
  assign have_word = state == DATA && cnt != 2'd0 && wcnt != len;
  assign pop = load && have_word && lo;
  assign cnt_next = cnt + 2'(push) - 2'(pop);
  // buffered words plus words in flight never exceed the two skid slots
  assign issue = (state == AHDR || state == DATA) && rcnt != len && ({1'b0, cnt_next} + 3'(ram_rd)) < 3'd2;
  always_comb hbyte = hcnt == 3'd0 ? seq[15:8] : hcnt == 3'd1 ? seq[7:0] : hcnt == 3'd2 ? {7'b0, err} :
                      hcnt == 3'd3 ? 8'h00 : hcnt == 3'd4 ? len16[15:8] : len16[7:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      seq <= '0;
      err <= 1'b0;
      len <= '0;
      rcnt <= '0;
      wcnt <= '0;
      hcnt <= '0;
      lo <= 1'b0;
      inflight <= 1'b0;
      cnt <= '0;
      buf0 <= '0;
      buf1 <= '0;
      ram_addr <= '0;
      ram_rd <= 1'b0;
      udp_hdr_valid <= 1'b0;
      udp_ip_dest_ip <= '0;
      udp_source_port <= '0;
      udp_dest_port <= '0;
      udp_length <= '0;
      udp_payload_axis_tdata <= '0;
      udp_payload_axis_tvalid <= 1'b0;
      udp_payload_axis_tlast <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      inflight <= ram_rd;
      cnt <= cnt_next;
      if (pop) buf0 <= buf1;
      if (push) begin
        if (cnt == 2'(pop)) buf0 <= ram_q;
        else buf1 <= ram_q;
      end
      ram_rd <= issue;
      if (issue) begin
        ram_addr <= rcnt[ADDR_WIDTH-1:0];
        rcnt <= rcnt + ONE;
      end
      case (state)
        IDLE: if (start) begin
          seq <= exec_seq;
          err <= exec_err;
          len <= len_in;
          udp_ip_dest_ip <= dest_ip;
          udp_source_port <= src_port;
          udp_dest_port <= dest_port;
          udp_length <= 16'd14 + 16'({len_in, 1'b0});
          hcnt <= '0;
          wcnt <= '0;
          rcnt <= '0;
          lo <= 1'b0;
          busy <= 1'b1;
          udp_hdr_valid <= 1'b1;
          state <= UHDR;
        end
        UHDR: if (udp_hdr_ready) begin
          udp_hdr_valid <= 1'b0;
          state <= AHDR;
        end
        AHDR: if (load && hcnt != HB) begin
          udp_payload_axis_tvalid <= 1'b1;
          udp_payload_axis_tdata <= hbyte;
          udp_payload_axis_tlast <= hcnt == HL && len == '0;
          hcnt <= hcnt + 3'd1;
          if (hcnt == HL && len != '0) state <= DATA;
        end
        DATA: if (load) begin
          udp_payload_axis_tvalid <= have_word;
          if (have_word) begin
            udp_payload_axis_tdata <= lo ? buf0[7:0] : buf0[15:8];
            udp_payload_axis_tlast <= lo && wcnt == len - ONE;
            lo <= !lo;
            if (lo) wcnt <= wcnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
      if (fire && udp_payload_axis_tlast) begin
        state <= IDLE;
        udp_payload_axis_tvalid <= 1'b0;
        udp_payload_axis_tlast <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
  skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, cnt} + 3'(inflight) + 3'(ram_rd)) <= 3'd2);
endmodule
